uart_pixel_packer: RTL
======================

Name: uart_pixel_packer

Overview:
Sits between uart_rx and the SDRAM write FIFO. Assembles a stream of received bytes into whole pixel words of configurable byte count and output width, and tracks position within a frame of configurable size. Flags FIFO overflow and resynchronises after idle gaps in the byte stream. Replaces the fixed one-byte-per-word zero-padded write path.

Parameters:
BYTES_PER_PIX, 2, bytes per pixel (1..3); assembled width AW = 8*BYTES_PER_PIX
PIX_W, 24, output pixel width; must satisfy PIX_W >= AW (and PIX_W = 24 when expansion is active)
H_PIX, 800, pixels per line
V_PIX, 480, lines per frame
TIMEOUT, 50000, idle clocks after which a partial pixel is discarded (>= 2)
MSB_FIRST, 1, 1: first byte lands in the MS byte of the assembled word; 0: in the LS byte

Ports:
sclk  in  1  system clock (UART domain, 50 MHz)
s_rst_n  in  1  reset, asynchronous, active-low
in_data  in  8  received byte
in_flag  in  1  one-cycle strobe, in_data valid
frame_rst  in  1  synchronous restart of byte/pixel/line counters
fifo_full  in  1  write FIFO full
pix_data  out  PIX_W  assembled pixel
pix_valid  out  1  one-cycle write strobe to FIFO (wr_en)
frame_done  out  1  one-cycle pulse with the last pixel of a frame
overflow  out  1  sticky: pixel dropped due to fifo_full; cleared only by reset or frame_rst
resync_err  out  1  one-cycle pulse when a partial pixel is discarded by timeout
pix_x  out  $clog2(H_PIX)  column of the next pixel to be written
pix_y  out  $clog2(V_PIX)  line of the next pixel to be written

Behaviour:
- Reset (async assert, sync release): all outputs 0, byte_cnt = 0, idle_cnt = 0, shift register 0.
- Byte collection: each in_flag stores in_data into the shift register (position set by MSB_FIRST) and increments byte_cnt.
- Completion: on the in_flag carrying byte BYTES_PER_PIX-1, byte_cnt wraps to 0. On the next clock, pix_valid = 1 for exactly one cycle, with pix_data holding the formatted word. Latency is 1 clock from the final byte's in_flag.
- Formatting: the AW-bit word is zero-extended in the MSBs to PIX_W (see Optional Feature for the exception).
- pix_data holds its value between strobes.
- Position counters:
  - pix_x and pix_y advance on every completed pixel, whether it was written or dropped, so frame alignment is preserved.
  - pix_x wraps at H_PIX-1 and increments pix_y.
  - At pix_x = H_PIX-1 and pix_y = V_PIX-1, frame_done asserts in the same cycle as pix_valid, and both counters return to 0.
- Overflow:
  - If fifo_full = 1 in the cycle the pixel completes (the final byte's in_flag cycle), pix_valid stays 0 and overflow is set.
  - The counters still advance.
- Timeout:
  - idle_cnt counts clocks while byte_cnt != 0 and in_flag = 0; it resets to 0 on any in_flag.
  - When idle_cnt reaches TIMEOUT-1: byte_cnt clears to 0, resync_err pulses for one cycle, and pix_x/pix_y do not advance.
  - idle_cnt holds at 0 while byte_cnt = 0.
- frame_rst:
  - Clears byte_cnt, idle_cnt, pix_x, pix_y and overflow on the next edge.
  - If frame_rst and in_flag occur in the same cycle, frame_rst wins and the byte is discarded.
  - A pending pix_valid from the previous cycle still issues.
- If in_flag and the timeout expiry coincide, in_flag wins: the byte is accepted and no resync_err is raised.
- BYTES_PER_PIX = 1: every in_flag completes a pixel.

Optional Feature:
- Macro: RGB565_EXPAND_EN.
- Defined, with BYTES_PER_PIX = 2: the 16-bit word is treated as RGB565 and expanded to RGB888 by MSB replication: {R[4:0],R[4:2]}, {G[5:0],G[5:4]}, {B[4:0],B[4:2]}.
- Defined, with BYTES_PER_PIX != 2: no effect.
- Not defined: plain zero-extension, and the display path keeps doing its own expansion.

Decomposition:
- Shared package (img_sys_pkg):
  - pixel format constants (RGB565/RGB888 field widths)
  - default frame geometry (800x480)
  - a function computing AW from BYTES_PER_PIX
- One sub-module, pix_fmt_expand: combinational 565->888 mapping, instantiated only under the macro. Reusable by the VGA output path.

Test Plan:
- BYTES_PER_PIX=2, MSB_FIRST=1, bytes 0xF8,0x1F → one cycle after the second in_flag, pix_valid=1 and pix_data=24'h00F81F. With RGB565_EXPAND_EN: 24'hFF00FF.
- H_PIX=4, V_PIX=2, 16 bytes streamed → 8 pix_valid strobes; frame_done coincides with the 8th strobe; pix_x/pix_y return to 0/0.
- fifo_full=1 during the 3rd pixel's completing byte → exactly 1 strobe missing, overflow=1 sticky, pix_x still advances to 3; frame_rst clears overflow.
- TIMEOUT=10: one byte, then idle for 10 clocks → resync_err pulses once, byte_cnt=0; next bytes 0x12,0x34 → pix_data=24'h001234.
- frame_rst asserted on the same cycle as an in_flag → byte discarded; the following two bytes form a pixel at pix_x=0.
- s_rst_n asserted mid-pixel (after the first byte) → all outputs 0 immediately; after release, a 2-byte pixel is assembled correctly.

Source files
------------

// File: rtl/img_sys_pkg.sv
// Shared image-system definitions: RGB565/RGB888 field widths, default
// frame geometry and the assembled-word width helper used by the packer.
package img_sys_pkg;

  localparam int RGB565_R_W  = 5;
  localparam int RGB565_G_W  = 6;
  localparam int RGB565_B_W  = 5;
  localparam int RGB565_W    = RGB565_R_W + RGB565_G_W + RGB565_B_W;

  localparam int RGB888_CH_W = 8;
  localparam int RGB888_W    = 3 * RGB888_CH_W;

  localparam int DEF_H_PIX   = 800;
  localparam int DEF_V_PIX   = 480;

  // Width of the word assembled from bytes_per_pix received bytes.
  function automatic int calc_aw(input int bytes_per_pix);
    return 8 * bytes_per_pix;
  endfunction

endpackage

// File: rtl/pix_fmt_expand.sv
// Combinational RGB565 -> RGB888 expansion by MSB replication, so full-scale
// channels map to 0xFF and zero stays zero. Shared with the VGA output path.
module pix_fmt_expand
  import img_sys_pkg::*;
(
  input  logic [RGB565_W-1:0] rgb565,
  output logic [RGB888_W-1:0] rgb888
);

  logic [RGB565_R_W-1:0] r5;
  logic [RGB565_G_W-1:0] g6;
  logic [RGB565_B_W-1:0] b5;

  assign r5 = rgb565[RGB565_W-1 -: RGB565_R_W];
  assign g6 = rgb565[RGB565_B_W +: RGB565_G_W];
  assign b5 = rgb565[RGB565_B_W-1:0];

  // Replicate each channel's top bits into the freshly opened LSBs.
  always_comb begin
    rgb888 = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs the uart_rx byte stream into pixel words for the SDRAM write FIFO and
// tracks the x/y position of the next pixel within the frame.
// Optional build macro: RGB565_EXPAND_EN (with BYTES_PER_PIX = 2 the word is
// expanded RGB565 -> RGB888 instead of being zero-extended).
//
// Output handshake: pix_valid is a one-cycle write strobe (the FIFO wr_en);
// there is no ready. fifo_full is sampled in the cycle the final byte of a
// pixel arrives: when high the pixel is dropped (no strobe) and overflow is
// set, but the position counters still advance to keep frame alignment.
module uart_pixel_packer
  import img_sys_pkg::*;
#(
  parameter int BYTES_PER_PIX = 2,
  parameter int PIX_W         = 24,
  parameter int H_PIX         = DEF_H_PIX,
  parameter int V_PIX         = DEF_V_PIX,
  parameter int TIMEOUT       = 50000,
  parameter int MSB_FIRST     = 1
) (
  input  logic                       sclk,
  input  logic                       s_rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_flag,
  input  logic                       frame_rst,
  input  logic                       fifo_full,
  output logic [PIX_W-1:0]           pix_data,
  output logic                       pix_valid,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       resync_err,
  output logic [$clog2(H_PIX)-1:0]   pix_x,
  output logic [$clog2(V_PIX)-1:0]   pix_y
);

  localparam int AW = calc_aw(BYTES_PER_PIX);
  localparam int XW = $clog2(H_PIX);
  localparam int YW = $clog2(V_PIX);
  localparam int IW = $clog2(TIMEOUT);

  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_PIX - 1);
  localparam logic [XW-1:0] LAST_X    = XW'(H_PIX - 1);
  localparam logic [YW-1:0] LAST_Y    = YW'(V_PIX - 1);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);

  logic [1:0]       byte_cnt_q,   byte_cnt_d;
  logic [IW-1:0]    idle_cnt_q,   idle_cnt_d;
  logic [AW-1:0]    sr_q,         sr_d;
  logic [PIX_W-1:0] pix_data_q,   pix_data_d;
  logic             pix_valid_q,  pix_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q,   overflow_d;
  logic             resync_err_q, resync_err_d;
  logic [XW-1:0]    pix_x_q,      pix_x_d;
  logic [YW-1:0]    pix_y_q,      pix_y_d;

  logic [1:0]       lane_sel;
  logic [PIX_W-1:0] pix_fmt;

  // Byte lane for the incoming byte: first byte in the MS lane when MSB_FIRST.
  always_comb begin
    lane_sel = (MSB_FIRST != 0) ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;
  end

  // Shift-register update; a frame_rst in the same cycle discards the byte.
  always_comb begin
    sr_d = sr_q;
    if (in_flag && !frame_rst) begin
      for (int i = 0; i < BYTES_PER_PIX; i++) begin
        if (lane_sel == 2'(i)) begin
          sr_d[i*8 +: 8] = in_data;
        end
      end
    end
  end

  // Output formatting of the word that includes the byte arriving this cycle.
`ifdef RGB565_EXPAND_EN
  if (BYTES_PER_PIX == 2) begin : g_expand
    logic [RGB888_W-1:0] rgb888;
    pix_fmt_expand u_expand (
      .rgb565 (sr_d),
      .rgb888 (rgb888)
    );
    assign pix_fmt = PIX_W'(rgb888);
  end else begin : g_zext
    assign pix_fmt = PIX_W'(sr_d);
  end
`else
  assign pix_fmt = PIX_W'(sr_d);
`endif

  // Control: byte counting, completion, position tracking, idle timeout.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    resync_err_d = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;

    if (frame_rst) begin
      // Restart wins over any byte arriving in the same cycle.
      byte_cnt_d = '0;
      idle_cnt_d = '0;
      pix_x_d    = '0;
      pix_y_d    = '0;
      overflow_d = 1'b0;
    end else if (in_flag) begin
      // A byte always beats a coinciding timeout expiry.
      idle_cnt_d = '0;
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d = '0;
        // Frame end is flagged even if the last pixel was dropped, so the
        // consumer still sees the frame boundary.
        frame_done_d = (pix_x_q == LAST_X) && (pix_y_q == LAST_Y);
        if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          pix_valid_d = 1'b1;
          pix_data_d  = pix_fmt;
        end
        if (pix_x_q == LAST_X) begin
          pix_x_d = '0;
          pix_y_d = (pix_y_q == LAST_Y) ? '0 : pix_y_q + YW'(1);
        end else begin
          pix_x_d = pix_x_q + XW'(1);
        end
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else if (byte_cnt_q != '0) begin
      if (idle_cnt_q == LAST_IDLE) begin
        byte_cnt_d   = '0;
        idle_cnt_d   = '0;
        resync_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      sr_q         <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      resync_err_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      sr_q         <= sr_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      resync_err_q <= resync_err_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign resync_err = resync_err_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;

endmodule
